btn_debounce_array: RTL

Parametrised N-channel push-button conditioner: per-channel two-flop synchroniser, counter-based debounce with programmable stable time, and registered press/release/long-press/auto-repeat pulses. Sits between the board button pins and the control FSMs, replacing per-button single-channel debouncers. A shared `tick` strobe scales all counters to a slow time base, for example 1 ms.

---
 rtl/btn_pkg.sv | 17 +
 rtl/btn_debounce_ch.sv | 132 +++++++++++++
 rtl/btn_debounce_array.sv | 47 ++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioner.
// Latency: n/a (types only).
// Backpressure: n/a.
package btn_pkg;

  // Default width of the per-channel debounce and hold counters.
  localparam int BTN_CNT_W = 16;

  // Per-channel hold tracking: idle, pressed (counting to long press),
  // held (counting auto-repeat periods).
  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2
  } hold_state_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, tick-scaled debounce, hold FSM with
// registered press/release/long/repeat pulses.
// Latency: STABLE_TICKS+2 edges from raw change to btn_state/pulse with tick=1.
// Backpressure: none; pulses are one-cycle strobes with no handshake.
// Ports: clk_i/reset_i (sync, active-high), tick_i time-base strobe,
//        button_i raw pin, btn_state_o debounced level (1 = pressed),
//        press/release/long/repeat_pulse_o one-cycle event strobes.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int CNT_W        = BTN_CNT_W,
  parameter int STABLE_TICKS = 4,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic tick_i,
  input  logic button_i,
  output logic btn_state_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic long_pulse_o,
  output logic repeat_pulse_o
);

  localparam logic [CNT_W-1:0] DCNT_TC = CNT_W'(STABLE_TICKS - 1);
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_TICKS - 1);
  localparam bit               REP_EN  = (REPEAT_TICKS != 0);

  logic             lvl;
  logic             s1_q, s2_q;
  logic             state_q;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] hcnt_q;
  hold_state_t      hold_q;
  logic             press_q, release_q, long_q, repeat_q;
  logic             flip, press_ev, release_ev, long_tc, rep_tc;

  assign lvl = ACTIVE_LOW ? ~button_i : button_i;

  // Agreement clears the count on every cycle, tick or not, so any bounce
  // back to the accepted level restarts the stability window.
  always_comb begin
    dcnt_d = dcnt_q;
    flip   = 1'b0;
    if (s2_q == state_q) begin
      dcnt_d = '0;
    end else if (tick_i) begin
      if (dcnt_q == DCNT_TC) begin
        flip   = 1'b1;
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + CNT_W'(1);
      end
    end
  end

  assign press_ev   = flip & ~state_q;
  assign release_ev = flip &  state_q;
  assign long_tc    = (hold_q == PRESSED) && tick_i && (hcnt_q == LONG_TC);
  assign rep_tc     = REP_EN && (hold_q == HELD) && tick_i && (hcnt_q == REP_TC);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= 1'b0;
      dcnt_q    <= '0;
      hcnt_q    <= '0;
      hold_q    <= RELEASED;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      s1_q      <= lvl;
      s2_q      <= s1_q;
      dcnt_q    <= dcnt_d;
      press_q   <= press_ev;
      release_q <= release_ev;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      if (flip) state_q <= ~state_q;

      // A release flip overrides any coincident long/repeat terminal count.
      if (release_ev) begin
        hold_q <= RELEASED;
        hcnt_q <= '0;
      end else begin
        case (hold_q)
          RELEASED: begin
            if (press_ev) begin
              hold_q <= PRESSED;
              hcnt_q <= '0;
            end
          end
          PRESSED: begin
            if (long_tc) begin
              hold_q <= HELD;
              long_q <= 1'b1;
              hcnt_q <= '0;
            end else if (tick_i) begin
              hcnt_q <= hcnt_q + CNT_W'(1);
            end
          end
          HELD: begin
            if (rep_tc) begin
              repeat_q <= 1'b1;
              hcnt_q   <= '0;
            end else if (tick_i && REP_EN) begin
              hcnt_q <= hcnt_q + CNT_W'(1);
            end
          end
          default: begin
            hold_q <= RELEASED;
            hcnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign btn_state_o     = state_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;
  assign long_pulse_o    = long_q;
  assign repeat_pulse_o  = repeat_q;

endmodule

// File: rtl/btn_debounce_array.sv
// N_CH independent push-button conditioners sharing one tick time base.
// Latency: STABLE_TICKS+2 edges from raw pin change to btn_state/pulse with tick=1.
// Backpressure: none; all outputs are registered one-cycle strobes or levels.
// Ports: clk, reset (sync, active-high), tick shared strobe, button[N_CH] raw pins,
//        btn_state debounced levels, press/release/long/repeat_pulse per channel.
module btn_debounce_array
  import btn_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int CNT_W        = BTN_CNT_W,
  parameter int STABLE_TICKS = 4,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] btn_state,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    btn_debounce_ch #(
      .CNT_W        (CNT_W),
      .STABLE_TICKS (STABLE_TICKS),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk_i           (clk),
      .reset_i         (reset),
      .tick_i          (tick),
      .button_i        (button[g]),
      .btn_state_o     (btn_state[g]),
      .press_pulse_o   (press_pulse[g]),
      .release_pulse_o (release_pulse[g]),
      .long_pulse_o    (long_pulse[g]),
      .repeat_pulse_o  (repeat_pulse[g])
    );
  end

endmodule
